// File: rtl/uart_rx_if.sv
// Byte handshake between uart_rx (master) and the card logic (slave),
// plus the one-cycle framing/overrun error pulses.
interface uart_rx_if;
   logic       o_valid;
   logic [7:0] o_data;
   logic       i_ready;
   logic       o_frameError;
   logic       o_overrun;

   modport master (output o_valid, o_data, o_frameError, o_overrun, input i_ready);
   modport slave  (input o_valid, o_data, o_frameError, o_overrun, output i_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8N2 accepted) with valid/ready output and error pulses.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module uart_rx #(
   parameter int CLK_DIVIDE = 868
`ifdef UART_RX_FIFO_EN
   ,
   parameter int FIFO_DEPTH = 4
`endif
) (
   input  logic      i_clk,
   input  logic      i_resetn,
   input  logic      i_serialIn,
   uart_rx_if.master rx_if
);
   localparam int            CW       = $clog2(CLK_DIVIDE) + 1;
   localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIVIDE / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIVIDE);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

   logic          sync_q;
   logic          rx_q;
   state_t        state_q, state_d;
   logic [CW-1:0] clk_count_q, clk_count_d;
   logic [2:0]    bit_count_q, bit_count_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_error_q, frame_error_d;
   logic          overrun_q, overrun_d;
   logic          push;

   always_comb begin
      state_d       = state_q;
      clk_count_d   = clk_count_q + CNT_ONE;
      bit_count_d   = bit_count_q;
      shift_d       = shift_q;
      push          = 1'b0;
      frame_error_d = 1'b0;
      case (state_q)
         WAIT_IDLE: if (rx_q) state_d = IDLE;
         IDLE: begin
            if (!rx_q) begin
               clk_count_d = '0;
               state_d     = START;
            end
         end
         START: begin
            if (clk_count_q == HALF_BIT) begin
               if (!rx_q) begin
                  clk_count_d = '0;
                  bit_count_d = '0;
                  state_d     = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (clk_count_q == FULL_BIT) begin
               shift_d     = {rx_q, shift_q[7:1]};
               clk_count_d = '0;
               if (bit_count_q == 3'd7) state_d = STOP;
               else                     bit_count_d = bit_count_q + 3'd1;
            end
         end
         STOP: begin
            // Only one stop bit is checked; a second one just reads as idle.
            if (clk_count_q == FULL_BIT) begin
               if (rx_q) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = WAIT_IDLE;
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   // Synchronizer flops reset high so a held-low line is not mistaken for a start.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         sync_q        <= 1'b1;
         rx_q          <= 1'b1;
         state_q       <= WAIT_IDLE;
         clk_count_q   <= '0;
         bit_count_q   <= '0;
         shift_q       <= '0;
         frame_error_q <= 1'b0;
      end else begin
         sync_q        <= i_serialIn;
         rx_q          <= sync_q;
         state_q       <= state_d;
         clk_count_q   <= clk_count_d;
         bit_count_q   <= bit_count_d;
         shift_q       <= shift_d;
         frame_error_q <= frame_error_d;
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        empty, full, pop;

   // The extra pointer bit tells a full FIFO from an empty one.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && rx_if.i_ready;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      overrun_d = 1'b0;
      if (push) begin
         if (!full || pop) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_if.o_valid = !empty;
   assign rx_if.o_data  = mem_q[rd_ptr_q[AW-1:0]];
`else
   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;
   logic       pop;

   assign pop = valid_q && rx_if.i_ready;

   // A pop frees the register in the same cycle, so a simultaneous push is kept.
   always_comb begin
      valid_d   = valid_q && !pop;
      data_d    = data_q;
      overrun_d = 1'b0;
      if (push) begin
         if (!valid_q || pop) begin
            valid_d = 1'b1;
            data_d  = shift_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_if.o_valid = valid_q;
   assign rx_if.o_data  = data_q;
`endif

   assign rx_if.o_frameError = frame_error_q;
   assign rx_if.o_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are scheduled into a queue-based storage
// model that is compared against the DUT outputs every cycle.
module tb_uart_rx;
   localparam int CLK_DIVIDE = 15;
   localparam int BIT        = CLK_DIVIDE + 1;
   localparam int LAT        = 2 + 1 + CLK_DIVIDE / 2 + 9 * BIT + 1;
`ifdef UART_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic i_clk      = 1'b0;
   logic i_resetn   = 1'b0;
   logic i_serialIn = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.CLK_DIVIDE(CLK_DIVIDE)) dut (
      .i_clk      (i_clk),
      .i_resetn   (i_resetn),
      .i_serialIn (i_serialIn),
      .rx_if      (bus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int         cyc;
      bit         ferr;
      logic [7:0] b;
   } ev_t;

   ev_t        ev_q[$];
   logic [7:0] model_q[$];
   logic [7:0] log_q[$];
   int cyc = 0, errors = 0, checks = 0;
   int mdl_fe = 0, mdl_ov = 0, dut_fe = 0, dut_ov = 0, first_valid = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Each byte lands in storage LAT cycles after its start edge is driven.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      ev_q.push_back('{cyc + LAT, !stop_bit, b});
      i_serialIn = 1'b0;
      repeat (BIT) @(negedge i_clk);
      for (int k = 0; k < 8; k++) begin
         i_serialIn = b[k];
         repeat (BIT) @(negedge i_clk);
      end
      i_serialIn = stop_bit;
      repeat (BIT) @(negedge i_clk);
   endtask

   task automatic idle(input int n);
      i_serialIn = 1'b1;
      repeat (n) @(negedge i_clk);
   endtask

   initial begin : compare
      ev_t e;
      bit  exp_fe, exp_ov, pop;
      forever begin
         @(posedge i_clk);
         #1;
         cyc++;
         exp_fe = 1'b0;
         exp_ov = 1'b0;
         if (!i_resetn) begin
            model_q.delete();
            ev_q.delete();
            check("o_data_in_reset", 32'(bus.o_data), 32'd0);
         end else begin
            pop = (model_q.size() != 0) && bus.i_ready;
            if (pop) log_q.push_back(model_q.pop_front());
            while (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
               e = ev_q.pop_front();
               if (e.ferr) begin
                  exp_fe = 1'b1;
                  mdl_fe++;
               end else if (model_q.size() < CAP) begin
                  model_q.push_back(e.b);
               end else begin
                  exp_ov = 1'b1;
                  mdl_ov++;
               end
            end
         end
         if (bus.o_frameError) dut_fe++;
         if (bus.o_overrun) dut_ov++;
         if (bus.o_valid && first_valid < 0) first_valid = cyc;
         check("o_valid", 32'(bus.o_valid), 32'(model_q.size() != 0));
         if (model_q.size() != 0) check("o_data", 32'(bus.o_data), 32'(model_q[0]));
         check("o_frameError", 32'(bus.o_frameError), 32'(exp_fe));
         check("o_overrun", 32'(bus.o_overrun), 32'(exp_ov));
      end
   end

   initial begin : stim
      int         start;
      logic [7:0] exp_log[$];
      bus.i_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_valid", 32'(bus.o_valid), 32'd0);
      check("reset_data", 32'(bus.o_data), 32'h00);
      check("reset_frameError", 32'(bus.o_frameError), 32'd0);
      check("reset_overrun", 32'(bus.o_overrun), 32'd0);
      i_resetn = 1'b1;
      repeat (4) @(negedge i_clk);

      // Single 8N2 byte, consumer always ready
      bus.i_ready = 1'b1;
      start = cyc;
      send_byte(8'hA5, 1'b1);
      idle(BIT);
      check("latency_in_window", 32'((first_valid >= start + LAT - 1) && (first_valid <= start + LAT + 1)), 32'd1);
      check("log_after_A5", 32'(log_q.size()), 32'd1);
      check("first_byte", 32'(log_q[0]), 32'hA5);

      // Start-bit glitch, then a clean byte
      i_serialIn = 1'b0;
      repeat (4) @(negedge i_clk);
      idle(2 * BIT);
      send_byte(8'h3C, 1'b1);
      idle(BIT);
      check("log_after_glitch", 32'(log_q.size()), 32'd2);

      // Stop bit low, line held low, then recovery
      send_byte(8'hFF, 1'b0);
      repeat (3 * BIT) @(negedge i_clk);
      idle(2 * BIT);
      send_byte(8'h12, 1'b1);
      idle(BIT);
      check("frame_errors_model", 32'(mdl_fe), 32'd1);
      check("frame_errors_dut", 32'(dut_fe), 32'd1);

      // Consumer stalled: storage fills, later bytes overrun
      bus.i_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         send_byte(8'(b), 1'b1);
         idle(BIT);
      end
      check("overruns_model", 32'(mdl_ov), 32'(5 - CAP));
      check("overruns_dut", 32'(dut_ov), 32'(5 - CAP));
      bus.i_ready = 1'b1;
      repeat (8) @(negedge i_clk);
      bus.i_ready = 1'b0;

      // Fill storage, then pop exactly in the cycle of the next push
      for (int b = 0; b < CAP; b++) begin
         send_byte(8'h71 + 8'(b), 1'b1);
         idle(BIT);
      end
      fork
         send_byte(8'h88, 1'b1);
         begin
            repeat (LAT - 1) @(negedge i_clk);
            bus.i_ready = 1'b1;
            @(negedge i_clk);
            bus.i_ready = 1'b0;
         end
      join
      idle(BIT);
      check("no_overrun_on_pop_push", 32'(dut_ov), 32'(5 - CAP));
      bus.i_ready = 1'b1;
      repeat (8) @(negedge i_clk);

      // Reset in the middle of data bit 3 with the line low
      i_serialIn = 1'b0;
      repeat (4 * BIT + BIT / 2) @(negedge i_clk);
      i_resetn = 1'b0;
      repeat (5) @(negedge i_clk);
      check("midreset_valid", 32'(bus.o_valid), 32'd0);
      check("midreset_frameError", 32'(bus.o_frameError), 32'd0);
      i_resetn = 1'b1;
      repeat (3) @(negedge i_clk);
      idle(2 * BIT);
      send_byte(8'h5A, 1'b1);
      idle(2 * BIT);
      check("frame_errors_final", 32'(dut_fe), 32'd1);

      exp_log = {8'hA5, 8'h3C, 8'h12};
      for (int b = 1; b <= CAP; b++) exp_log.push_back(8'(b));
      for (int b = 0; b < CAP; b++) exp_log.push_back(8'h71 + 8'(b));
      exp_log.push_back(8'h88);
      exp_log.push_back(8'h5A);
      check("log_size", 32'(log_q.size()), 32'(exp_log.size()));
      foreach (exp_log[i]) check("log_entry", 32'(log_q[i]), 32'(exp_log[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
